// File: rtl/axi_mem_bridge.sv
// AXI4 slave to single-port SRAM request/grant/rvalid bridge, one burst and one memory request in flight.
// Optional burst error checking is compiled in with `define AXI_MEM_BRIDGE_ERR_CHECK_EN.
package ariane_axi;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned UserWidth = 1;

    typedef logic [IdWidth-1:0]     id_t;
    typedef logic [AddrWidth-1:0]   addr_t;
    typedef logic [DataWidth-1:0]   data_t;
    typedef logic [DataWidth/8-1:0] strb_t;
    typedef logic [UserWidth-1:0]   user_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        user_t      user;
    } aw_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } ar_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_mem_bridge #(
    parameter int unsigned AddrWidth = ariane_axi::AddrWidth,
    parameter int unsigned DataWidth = ariane_axi::DataWidth,
    parameter int unsigned IdWidth   = ariane_axi::IdWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  ariane_axi::req_t       axi_req_i,
    output ariane_axi::resp_t      axi_resp_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i
);
    localparam int unsigned OffW = $clog2(DataWidth/8);
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_RESP} state_e;

    state_e                 state_q, state_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic [AddrWidth-1:0]   addr_q, addr_d, addr_next;
    logic [7:0]             cnt_q, cnt_d;
    logic [2:0]             size_q, size_d;
    logic [1:0]             burst_q, burst_d;
    logic                   prio_q, prio_d;   // 0 = read wins a tie, 1 = write wins
    logic [DataWidth-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
    logic [DataWidth/8-1:0] be_q, be_d;
    logic                   err_q, err_d;
    logic                   ar_err, aw_err, w_err;
    logic                   unused_req;

    assign unused_req = ^axi_req_i;

`ifdef AXI_MEM_BRIDGE_ERR_CHECK_EN
    assign ar_err = (axi_req_i.ar.burst == BurstWrap) || (axi_req_i.ar.size > 3'(OffW));
    assign aw_err = (axi_req_i.aw.burst == BurstWrap) || (axi_req_i.aw.size > 3'(OffW))
                 || (axi_req_i.aw.atop != '0);
    assign w_err  = axi_req_i.w.last != (cnt_q == '0);
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
    assign w_err  = 1'b0;
`endif

    // WRAP bursts advance like INCR; the address space wraps modulo 2^AddrWidth.
    assign addr_next   = (burst_q == BurstFixed) ? addr_q : addr_q + (AddrWidth'(1) << size_q);
    assign mem_addr_o  = {addr_q[AddrWidth-1:OffW], OffW'(0)};
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        burst_d = burst_q;
        prio_d  = prio_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        axi_resp_o        = '0;
        axi_resp_o.r.id   = id_q;
        axi_resp_o.r.data = rdata_q;
        axi_resp_o.r.resp = err_q ? RespSlvErr : RespOkay;
        axi_resp_o.r.last = (state_q == RD_RESP) && (cnt_q == '0);
        axi_resp_o.b.id   = id_q;
        axi_resp_o.b.resp = err_q ? RespSlvErr : RespOkay;

        case (state_q)
            IDLE: begin
                axi_resp_o.ar_ready = axi_req_i.ar_valid && (!axi_req_i.aw_valid || !prio_q);
                axi_resp_o.aw_ready = axi_req_i.aw_valid && (!axi_req_i.ar_valid || prio_q);
                if (axi_req_i.ar_valid && axi_req_i.aw_valid) prio_d = ~prio_q;
                if (axi_resp_o.ar_ready) begin
                    id_d    = axi_req_i.ar.id;
                    addr_d  = axi_req_i.ar.addr;
                    cnt_d   = axi_req_i.ar.len;
                    size_d  = axi_req_i.ar.size;
                    burst_d = axi_req_i.ar.burst;
                    err_d   = ar_err;
                    state_d = RD_REQ;
                end else if (axi_resp_o.aw_ready) begin
                    id_d    = axi_req_i.aw.id;
                    addr_d  = axi_req_i.aw.addr;
                    cnt_d   = axi_req_i.aw.len;
                    size_d  = axi_req_i.aw.size;
                    burst_d = axi_req_i.aw.burst;
                    err_d   = aw_err;
                    state_d = WR_DATA;
                end
            end
            RD_REQ: begin
                if (err_q) begin
                    rdata_d = '0;
                    state_d = RD_RESP;
                end else begin
                    mem_req_o = 1'b1;
                    if (mem_gnt_i) state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                axi_resp_o.r_valid = 1'b1;
                if (axi_req_i.r_ready) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = addr_next;
                        state_d = RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                axi_resp_o.w_ready = 1'b1;
                if (axi_req_i.w_valid) begin
                    wdata_d = axi_req_i.w.data;
                    be_d    = axi_req_i.w.strb;
                    err_d   = err_q | w_err;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                mem_req_o = !err_q;
                mem_we_o  = !err_q;
                if (mem_gnt_i || err_q) begin
                    if (cnt_q == '0) begin
                        state_d = WR_RESP;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = addr_next;
                        state_d = WR_DATA;
                    end
                end
            end
            WR_RESP: begin
                axi_resp_o.b_valid = 1'b1;
                if (axi_req_i.b_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            prio_q  <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            prio_q  <= prio_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_axi_mem_bridge.sv
// Directed bench for axi_mem_bridge: a small grant/rvalid memory model logs every granted request.
module tb_axi_mem_bridge;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ariane_axi::req_t  req;
    ariane_axi::resp_t resp;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_be;

    logic        gnt_en = 1'b1, rv_en = 1'b1, rv_manual = 1'b0, rv_q = 1'b0;
    logic [63:0] rd_base = '0, rdata_q = '0;
    logic [31:0] log_addr  [0:127];
    logic [63:0] log_wdata [0:127];
    logic [7:0]  log_be    [0:127];
    logic        log_we    [0:127];
    int          log_n = 0;
    int          vecs = 0, errs = 0;
    logic [63:0] wr_data [4];
    logic [7:0]  wr_strb [4];
    logic [31:0] wr_addr [4];

    axi_mem_bridge dut (
        .clk_i(clk), .rst_i(rst), .axi_req_i(req), .axi_resp_o(resp),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    assign mem_gnt    = mem_req && gnt_en;
    assign mem_rvalid = rv_q | rv_manual;
    assign mem_rdata  = rdata_q;

    always @(posedge clk) begin
        rv_q <= rv_en && mem_req && mem_gnt && !mem_we;
        if (mem_req && mem_gnt) begin
            rdata_q <= rd_base ^ {32'h0, mem_addr};
            if (log_n < 128) begin
                log_addr[log_n]  <= mem_addr;
                log_wdata[log_n] <= mem_wdata;
                log_be[log_n]    <= mem_be;
                log_we[log_n]    <= mem_we;
                log_n <= log_n + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        req.ar.id = id; req.ar.addr = addr; req.ar.len = len; req.ar.size = size; req.ar.burst = burst;
        req.ar_valid = 1'b1; #1;
        while (!resp.ar_ready && n < 50) begin tick(); n++; end
        vecs++;
        if (n >= 50) begin errs++; $display("FAIL ar_handshake: ar_ready=%b required 1", resp.ar_ready); end
        tick();
        req.ar_valid = 1'b0;
    endtask

    task automatic drive_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop);
        int n = 0;
        req.aw.id = id; req.aw.addr = addr; req.aw.len = len; req.aw.size = size; req.aw.burst = burst;
        req.aw.atop = atop;
        req.aw_valid = 1'b1; #1;
        while (!resp.aw_ready && n < 50) begin tick(); n++; end
        vecs++;
        if (n >= 50) begin errs++; $display("FAIL aw_handshake: aw_ready=%b required 1", resp.aw_ready); end
        tick();
        req.aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic last);
        int n = 0;
        req.w.data = d; req.w.strb = s; req.w.last = last;
        req.w_valid = 1'b1; #1;
        while (!resp.w_ready && n < 50) begin tick(); n++; end
        vecs++;
        if (n >= 50) begin errs++; $display("FAIL w_handshake: w_ready=%b required 1", resp.w_ready); end
        tick();
        req.w_valid = 1'b0;
    endtask

    task automatic get_r(output logic [63:0] d, output logic [3:0] id, output logic [1:0] rs,
                         output logic last);
        int n = 0;
        req.r_ready = 1'b1; #1;
        while (!resp.r_valid && n < 50) begin tick(); n++; end
        vecs++;
        if (n >= 50) begin errs++; $display("FAIL r_wait: r_valid=%b required 1", resp.r_valid); end
        d = resp.r.data; id = resp.r.id; rs = resp.r.resp; last = resp.r.last;
        tick();
        req.r_ready = 1'b0;
    endtask

    task automatic get_b(output logic [3:0] id, output logic [1:0] rs);
        int n = 0;
        req.b_ready = 1'b1; #1;
        while (!resp.b_valid && n < 50) begin tick(); n++; end
        vecs++;
        if (n >= 50) begin errs++; $display("FAIL b_wait: b_valid=%b required 1", resp.b_valid); end
        id = resp.b.id; rs = resp.b.resp;
        tick();
        req.b_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    endtask

    task automatic test_reset();
        req = '0; rst = 1'b1;
        tick(); tick();
        vecs++;
        if ({mem_req, mem_we, resp.ar_ready, resp.aw_ready, resp.w_ready, resp.r_valid, resp.b_valid} !== 7'b0) begin
            errs++; $display("FAIL reset_ctrl: got %b required 0000000",
                {mem_req, mem_we, resp.ar_ready, resp.aw_ready, resp.w_ready, resp.r_valid, resp.b_valid});
        end
        vecs++;
        if (resp.r.data !== 64'h0 || mem_addr !== 32'h0 || mem_wdata !== 64'h0) begin
            errs++; $display("FAIL reset_data: r.data=%h addr=%h wdata=%h required 0", resp.r.data, mem_addr, mem_wdata);
        end
        rst = 1'b0; tick();
    endtask

    task automatic test_single_read();
        logic [63:0] d; logic [3:0] id; logic [1:0] rs; logic last;
        int s = log_n;
        rd_base = 64'hDEADAEEF;
        drive_ar(4'd3, 32'h1000, 8'd0, 3'd3, INCR);
        vecs++;
        if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h1000) begin
            errs++; $display("FAIL rd_req_n1: req/we=%b addr=%h required 10 00001000", {mem_req, mem_we}, mem_addr);
        end
        tick();
        vecs++;
        if (resp.r_valid !== 1'b0) begin errs++; $display("FAIL rd_lat_n2: r_valid=%b required 0", resp.r_valid); end
        tick();
        vecs++;
        if (resp.r_valid !== 1'b1) begin errs++; $display("FAIL rd_lat_n3: r_valid=%b required 1", resp.r_valid); end
        get_r(d, id, rs, last);
        vecs++;
        if (d !== 64'hDEADBEEF || id !== 4'd3 || rs !== 2'b00 || last !== 1'b1) begin
            errs++; $display("FAIL rd_single: data=%h id=%0d resp=%b last=%b required deadbeef 3 00 1", d, id, rs, last);
        end
        vecs++;
        if (log_n - s !== 1 || log_addr[s] !== 32'h1000 || log_we[s] !== 1'b0) begin
            errs++; $display("FAIL rd_single_mem: count=%0d addr=%h required 1 00001000", log_n - s, log_addr[s]);
        end
    endtask

    task automatic test_incr_write();
        logic [3:0] id; logic [1:0] rs;
        int s = log_n;
        wr_data = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F, 64'hA5A5A5A55A5A5A5A};
        wr_strb = '{8'hFF, 8'h0F, 8'hF0, 8'h81};
        wr_addr = '{32'h2000, 32'h2008, 32'h2010, 32'h2018};
        drive_aw(4'd5, 32'h2000, 8'd3, 3'd3, INCR, 6'h0);
        for (int i = 0; i < 4; i++) send_w(wr_data[i], wr_strb[i], i == 3);
        get_b(id, rs);
        vecs++;
        if (id !== 4'd5 || rs !== 2'b00) begin
            errs++; $display("FAIL wr_b: id=%0d resp=%b required 5 00", id, rs);
        end
        vecs++;
        if (log_n - s !== 4) begin errs++; $display("FAIL wr_count: got %0d required 4", log_n - s); end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (log_addr[s+i] !== wr_addr[i] || log_wdata[s+i] !== wr_data[i] || log_be[s+i] !== wr_strb[i]
                || log_we[s+i] !== 1'b1) begin
                errs++; $display("FAIL wr_beat%0d: addr=%h data=%h be=%h we=%b required %h %h %h 1", i,
                    log_addr[s+i], log_wdata[s+i], log_be[s+i], log_we[s+i], wr_addr[i], wr_data[i], wr_strb[i]);
            end
        end
    endtask

    task automatic test_contention();
        logic [63:0] d; logic [3:0] id; logic [1:0] rs; logic last;
        do_reset();
        req.ar.id = 4'd1; req.ar.addr = 32'h100; req.ar.len = 8'd0; req.ar.size = 3'd3; req.ar.burst = INCR;
        req.aw.id = 4'd2; req.aw.addr = 32'h200; req.aw.len = 8'd0; req.aw.size = 3'd3; req.aw.burst = INCR;
        req.aw.atop = 6'h0;
        req.ar_valid = 1'b1; req.aw_valid = 1'b1; #1;
        vecs++;
        if ({resp.ar_ready, resp.aw_ready} !== 2'b10) begin
            errs++; $display("FAIL contend_first: ar/aw_ready=%b required 10", {resp.ar_ready, resp.aw_ready});
        end
        tick();
        req.ar_valid = 1'b0; req.aw_valid = 1'b0;
        get_r(d, id, rs, last);
        vecs++;
        if (id !== 4'd1) begin errs++; $display("FAIL contend_rd_id: got %0d required 1", id); end
        req.ar_valid = 1'b1; req.aw_valid = 1'b1; #1;
        vecs++;
        if ({resp.ar_ready, resp.aw_ready} !== 2'b01) begin
            errs++; $display("FAIL contend_second: ar/aw_ready=%b required 01", {resp.ar_ready, resp.aw_ready});
        end
        tick();
        req.ar_valid = 1'b0; req.aw_valid = 1'b0;
        send_w(64'h1, 8'hFF, 1'b1);
        get_b(id, rs);
        vecs++;
        if (id !== 4'd2 || rs !== 2'b00) begin errs++; $display("FAIL contend_b: id=%0d resp=%b required 2 00", id, rs); end
    endtask

    task automatic test_backpressure();
        logic [63:0] d; logic [3:0] id; logic [1:0] rs; logic last;
        int n = 0;
        rd_base = 64'hCAFE0000_00000000;
        drive_ar(4'd7, 32'h3000, 8'd1, 3'd3, INCR);
        get_r(d, id, rs, last);
        vecs++;
        if (d !== 64'hCAFE0000_00003000 || last !== 1'b0) begin
            errs++; $display("FAIL bp_beat0: data=%h last=%b required cafe000000003000 0", d, last);
        end
        while (!resp.r_valid && n < 20) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            tick();
            vecs++;
            if (resp.r_valid !== 1'b1 || resp.r.data !== 64'hCAFE0000_00003008 || mem_req !== 1'b0) begin
                errs++; $display("FAIL bp_hold%0d: r_valid=%b data=%h mem_req=%b required 1 cafe000000003008 0",
                    i, resp.r_valid, resp.r.data, mem_req);
            end
        end
        get_r(d, id, rs, last);
        vecs++;
        if (d !== 64'hCAFE0000_00003008 || last !== 1'b1 || id !== 4'd7) begin
            errs++; $display("FAIL bp_beat1: data=%h last=%b id=%0d required cafe000000003008 1 7", d, last, id);
        end
        gnt_en = 1'b0;
        drive_ar(4'd8, 32'h3100, 8'd0, 3'd3, INCR);
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (mem_req !== 1'b1) begin errs++; $display("FAIL gnt_hold%0d: mem_req=%b required 1", i, mem_req); end
            tick();
        end
        gnt_en = 1'b1;
        get_r(d, id, rs, last);
        vecs++;
        if (d !== 64'hCAFE0000_00003100 || id !== 4'd8) begin
            errs++; $display("FAIL gnt_hold_data: data=%h id=%0d required cafe000000003100 8", d, id);
        end
    endtask

    task automatic test_edge_addr();
        logic [63:0] d; logic [3:0] id; logic [1:0] rs; logic last;
        int s = log_n;
        rd_base = 64'h5555_0000_0000_0000;
        drive_ar(4'd1, 32'hFFFF_FFF8, 8'd2, 3'd3, FIXED);
        for (int i = 0; i < 3; i++) begin
            get_r(d, id, rs, last);
            vecs++;
            if (d !== 64'h5555_0000_FFFF_FFF8 || last !== (i == 2)) begin
                errs++; $display("FAIL fixed_beat%0d: data=%h last=%b required 55550000fffffff8 %0d", i, d, last, i == 2);
            end
        end
        vecs++;
        if (log_n - s !== 3 || log_addr[s] !== 32'hFFFF_FFF8 || log_addr[s+1] !== 32'hFFFF_FFF8
            || log_addr[s+2] !== 32'hFFFF_FFF8) begin
            errs++; $display("FAIL fixed_addr: count=%0d addrs=%h %h %h required 3 x fffffff8",
                log_n - s, log_addr[s], log_addr[s+1], log_addr[s+2]);
        end
        s = log_n;
        drive_ar(4'd2, 32'hFFFF_FFF8, 8'd1, 3'd3, INCR);
        get_r(d, id, rs, last);
        get_r(d, id, rs, last);
        vecs++;
        if (d !== 64'h5555_0000_0000_0000 || last !== 1'b1) begin
            errs++; $display("FAIL wrap_data: data=%h last=%b required 5555000000000000 1", d, last);
        end
        vecs++;
        if (log_n - s !== 2 || log_addr[s] !== 32'hFFFF_FFF8 || log_addr[s+1] !== 32'h0) begin
            errs++; $display("FAIL wrap_addr: count=%0d addrs=%h %h required 2 fffffff8 00000000",
                log_n - s, log_addr[s], log_addr[s+1]);
        end
        rv_en = 1'b0;
        drive_ar(4'd3, 32'h400, 8'd0, 3'd3, INCR);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        vecs++;
        if ({mem_req, mem_we, resp.ar_ready, resp.aw_ready, resp.w_ready, resp.r_valid, resp.b_valid} !== 7'b0
            || resp.r.data !== 64'h0) begin
            errs++; $display("FAIL mid_reset: ctrl=%b data=%h required 0000000 0",
                {mem_req, mem_we, resp.ar_ready, resp.aw_ready, resp.w_ready, resp.r_valid, resp.b_valid}, resp.r.data);
        end
        rv_en = 1'b1; rv_manual = 1'b1; tick(); rv_manual = 1'b0; tick();
        vecs++;
        if (resp.r_valid !== 1'b0 || mem_req !== 1'b0) begin
            errs++; $display("FAIL late_rvalid: r_valid=%b mem_req=%b required 0 0", resp.r_valid, mem_req);
        end
        drive_ar(4'd4, 32'h408, 8'd0, 3'd3, INCR);
        get_r(d, id, rs, last);
        vecs++;
        if (d !== 64'h5555_0000_0000_0408 || id !== 4'd4 || rs !== 2'b00 || last !== 1'b1) begin
            errs++; $display("FAIL post_reset_rd: data=%h id=%0d resp=%b last=%b required 5555000000000408 4 00 1",
                d, id, rs, last);
        end
    endtask

`ifdef AXI_MEM_BRIDGE_ERR_CHECK_EN
    task automatic test_err_check();
        logic [63:0] d; logic [3:0] id; logic [1:0] rs; logic last;
        int s = log_n;
        drive_ar(4'd9, 32'h500, 8'd1, 3'd3, WRAP);
        for (int i = 0; i < 2; i++) begin
            get_r(d, id, rs, last);
            vecs++;
            if (d !== 64'h0 || rs !== 2'b10 || id !== 4'd9 || last !== (i == 1)) begin
                errs++; $display("FAIL err_wrap_beat%0d: data=%h resp=%b id=%0d last=%b required 0 10 9 %0d",
                    i, d, rs, id, last, i == 1);
            end
        end
        drive_aw(4'd10, 32'h600, 8'd1, 3'd3, INCR, 6'h20);
        send_w(64'h11, 8'hFF, 1'b0);
        send_w(64'h22, 8'hFF, 1'b1);
        get_b(id, rs);
        vecs++;
        if (rs !== 2'b10 || id !== 4'd10) begin errs++; $display("FAIL err_atop_b: resp=%b id=%0d required 10 10", rs, id); end
        vecs++;
        if (log_n - s !== 0) begin errs++; $display("FAIL err_no_mem: accesses=%0d required 0", log_n - s); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_incr_write();
        test_contention();
        test_backpressure();
        test_edge_addr();
`ifdef AXI_MEM_BRIDGE_ERR_CHECK_EN
        test_err_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/axi_mem_bridge.md
Name: axi_mem_bridge

Overview:
- AXI4 slave endpoint that consumes `ariane_axi::req_t` and produces `ariane_axi::resp_t`.
- Converts AXI bursts into a simple single-port SRAM-style request/grant/rvalid interface.
- Sits directly downstream of the core's AXI master port, in front of boot ROM / scratchpad / debug memory.
- Handles one transaction at a time: one burst in flight, one memory request outstanding.

Parameters:
- AddrWidth, ariane_axi::AddrWidth, AXI and memory address width.
- DataWidth, ariane_axi::DataWidth, AXI and memory data width; must be a power of two and at least 32.
- IdWidth, ariane_axi::IdWidth, AXI ID width, echoed on R and B.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- axi_req_i  input  ariane_axi::req_t  AXI request from the upstream master.
- axi_resp_o  output  ariane_axi::resp_t  AXI response to the upstream master.
- mem_req_o  output  1  memory request valid.
- mem_gnt_i  input  1  memory accepts the request this cycle.
- mem_we_o  output  1  1 = write.
- mem_addr_o  output  AddrWidth  byte address, aligned to DataWidth/8.
- mem_wdata_o  output  DataWidth  write data.
- mem_be_o  output  DataWidth/8  byte enables (copied from WSTRB).
- mem_rvalid_i  input  1  read data valid; arrives at least 1 cycle after the read grant.
- mem_rdata_i  input  DataWidth  read data.

Behaviour:
- Clock and reset (already decided): one clock, `clk_i`; reset `rst_i` is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - All `axi_resp_o` valid/ready bits = 0.
  - `mem_req_o` = 0, `mem_we_o` = 0.
  - Data fields = 0.
  - Priority bit = read.
- Reset asserted mid-burst: the transaction is abandoned. No R/B beat is issued afterwards. A late `mem_rvalid_i` is ignored.
- States: IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_RESP.
- IDLE:
  - `ar_ready` = `ar_valid` && (!`aw_valid` || prio==read).
  - `aw_ready` = `aw_valid` && (!`ar_valid` || prio==write).
  - On a handshake: latch id, addr, len, size, burst; beat counter = len; toggle prio only when both AR and AW were valid.
  - AR handshake -> RD_REQ. AW handshake -> WR_DATA.
- RD_REQ:
  - `mem_req_o` = 1, `mem_we_o` = 0.
  - `mem_gnt_i` -> RD_WAIT.
- RD_WAIT: `mem_rvalid_i` -> capture `mem_rdata_i` into the R register, then -> RD_RESP.
- RD_RESP:
  - `r_valid` = 1, `r.id` = latched id, `r.resp` = OKAY, `r.last` = (counter==0).
  - R fields are held stable until `r_ready`.
  - On the handshake: counter==0 -> IDLE; otherwise decrement the counter, advance the address, -> RD_REQ.
- WR_DATA:
  - `w_ready` = 1.
  - On a W handshake: capture data and strb, -> WR_REQ.
- WR_REQ:
  - `mem_req_o` = 1, `mem_we_o` = 1.
  - On `mem_gnt_i`: counter==0 -> WR_RESP; otherwise decrement, advance the address, -> WR_DATA.
  - `mem_rvalid_i` is ignored during writes.
- WR_RESP:
  - `b_valid` = 1, `b.id` = latched id, `b.resp` = OKAY.
  - `b_ready` -> IDLE.
- Address advance:
  - INCR: addr + (1<<size), modulo 2^AddrWidth (wrap-around permitted).
  - FIXED: unchanged.
  - WRAP: treated as INCR.
  - `mem_addr_o` = addr with the low log2(DataWidth/8) bits cleared.
- Beat count is taken from len only. `w.last` and `atop` are ignored.
- Latency: AR handshake in cycle N -> `mem_req_o` in N+1. With grant in N+1 and rvalid in N+2, `r_valid` is in N+3.
- Back-to-back bursts: a new AR/AW is accepted no earlier than the cycle after the state returns to IDLE.
- `user` fields are driven 0.

Optional Feature:
- Macro: `AXI_MEM_BRIDGE_ERR_CHECK_EN`.
- Defined: a burst is an error burst when burst==WRAP, or `atop`≠0, or size > log2(DataWidth/8), or a W beat arrives with `w.last` mismatched to counter==0.
- Error bursts still consume all beats. Memory is not accessed for them (`mem_req_o` stays 0, same-cycle state advance).
  - Reads return data 0 with resp SLVERR on every beat.
  - Writes return B resp SLVERR.
- Undefined: no checks; behaviour as in Behaviour above.

Test Plan:
- Single read: AR addr 0x1000, len 0, id 3; memory grants immediately, rvalid 1 cycle later with 0xDEADBEEF -> one R beat: data 0xDEADBEEF, id 3, last 1, OKAY; `r_valid` 3 cycles after the AR handshake.
- INCR write burst: AW addr 0x2000, len 3, size 3 (64-bit) -> memory writes at 0x2000, 0x2008, 0x2010, 0x2018 with strbs passed through; single B OKAY after the last grant.
- Contention: AR and AW both valid in the same cycle after reset -> AR accepted first; the next simultaneous pair grants AW.
- Backpressure: hold `r_ready` low 5 cycles on beat 1 of a len-1 read -> R data stable; no second `mem_req_o` until the handshake; `mem_gnt_i` held low 4 cycles -> `mem_req_o` stays high.
- Edge address and reset: FIXED read len 2 at 0xFFFF_FFF8 -> three requests to the same address. INCR from the top of the address space wraps to 0. `rst_i` pulsed during RD_WAIT -> all outputs 0 next cycle; the following read completes normally.
- With `AXI_MEM_BRIDGE_ERR_CHECK_EN`: WRAP read len 1 -> two R beats SLVERR, data 0, no `mem_req_o`; AW with `atop`=0x20 -> B SLVERR after all W beats are consumed.
